if_fetch_unit: RTL and testbench

//  Instruction-fetch stage: owns the PC, issues in-order word fetches to instruction memory,

---
 rtl/if_fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order word fetches, buffers returned words
// and hands {instr, pc} to decode. Optional misaligned-redirect fault via IF_MISALIGN_CHECK_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_fault
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

`ifdef IF_MISALIGN_CHECK_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD} state_t;

    state_t          state, state_nxt;
    logic [31:0]     pc, pend_pc, fault_pc, redirect_tgt;
    logic            pend_v, fault_pend;
    logic [CW-1:0]   inflight, bufcnt, drop_cnt, credits, inflight_nxt;
    logic [31:0]     pcq [DEPTH];
    logic [31:0]     buf_data [DEPTH];
    logic [31:0]     buf_pc [DEPTH];
    logic            buf_fault [DEPTH];
    logic [PW-1:0]   pq_wr, pq_rd, b_wr, b_rd;
    logic            accept, pop, dropping, push, misalign;

    // Free credits are derived so they can never drift from the occupancy counters.
    assign credits      = CW'(DEPTH) - inflight - bufcnt;
    assign accept       = imem_req_valid & imem_req_ready;
    assign pop          = id_valid & id_ready;
    assign dropping     = imem_rsp_valid && (drop_cnt != '0);
    assign push         = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign misalign     = MISALIGN_EN && (redirect_pc[1:0] != 2'b00);
    assign inflight_nxt = inflight + CW'(accept) - CW'(imem_rsp_valid);

    assign imem_req_addr = pc;
    assign id_valid      = (bufcnt != '0);
    assign id_instr      = id_valid ? buf_data[b_rd] : NOP_INSTR;
    assign id_pc         = buf_pc[b_rd];
    assign id_fault      = MISALIGN_EN && id_valid && buf_fault[b_rd];

    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        case (state)
            S_BOOT: state_nxt = S_FETCH;
            S_FETCH: begin
                imem_req_valid = (credits != '0);
                if (imem_req_valid && !imem_req_ready)
                    state_nxt = S_HOLD;
            end
            S_HOLD: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready)
                    state_nxt = S_FETCH;
            end
            default: state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_BOOT;
            pc         <= RESET_PC;
            pend_pc    <= RESET_PC;
            pend_v     <= 1'b0;
            fault_pc   <= RESET_PC;
            fault_pend <= 1'b0;
            inflight   <= '0;
            bufcnt     <= '0;
            drop_cnt   <= '0;
            pq_wr      <= '0;
            pq_rd      <= '0;
            b_wr       <= '0;
            b_rd       <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= inflight_nxt;
            if (accept)
                pq_wr <= pq_wr + PW'(1);
            if (imem_rsp_valid)
                pq_rd <= pq_rd + PW'(1);

            // A request still being presented when a redirect lands must stay stable,
            // so the target is parked until that request is accepted.
            if (accept) begin
                pend_v <= 1'b0;
                if (redirect_valid)
                    pc <= redirect_tgt;
                else if (pend_v)
                    pc <= pend_pc;
                else
                    pc <= pc + 32'd4;
            end else if (redirect_valid) begin
                if (imem_req_valid) begin
                    pend_pc <= redirect_tgt;
                    pend_v  <= 1'b1;
                end else begin
                    pc <= redirect_tgt;
                end
            end

            if (redirect_valid) begin
                drop_cnt   <= inflight_nxt;
                bufcnt     <= '0;
                b_wr       <= '0;
                b_rd       <= '0;
                fault_pend <= misalign;
                fault_pc   <= redirect_pc;
            end else begin
                drop_cnt <= drop_cnt - CW'(dropping) + CW'(accept && pend_v);
                bufcnt   <= bufcnt + CW'(push) - CW'(pop);
                if (push) begin
                    b_wr       <= b_wr + PW'(1);
                    fault_pend <= 1'b0;
                end
                if (pop)
                    b_rd <= b_rd + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc[i]    <= RESET_PC;
                buf_fault[i] <= 1'b0;
            end
        end else if (push) begin
            buf_pc[b_wr]    <= fault_pend ? fault_pc : pcq[pq_rd];
            buf_fault[b_wr] <= fault_pend;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            buf_data[b_wr] <= imem_rsp_data;
    end

    always_ff @(posedge clk) begin
        if (accept)
            pcq[pq_wr] <= pc;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: cycle-exact vector table plus redirect/wrap/reset sequences.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_fault;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] memq[$];

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] rpc;
        logic        rv;
        logic [31:0] addr;
        logic        idv;
        logic [31:0] pc;
    } vec_t;
    vec_t vecs[33];

    if_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_fault(id_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory answers in order, one cycle after accept, while rspen is high.
    task automatic applyStimulus(input logic rdy, input logic idr, input logic rspen,
                                 input logic redir, input logic [31:0] rpc);
        imem_req_ready = rdy;
        id_ready       = idr;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rsp_valid = rspen && (memq.size() > 0);
        imem_rsp_data  = imem_rsp_valid ? memData(memq[0]) : 32'h0;
        #1;
    endtask

    task automatic tick();
        logic        acc, rv;
        logic [31:0] a;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        rv  = imem_rsp_valid;
        @(posedge clk);
        #1;
        if (rv) void'(memq.pop_front());
        if (acc) memq.push_back(a);
    endtask

    task automatic waitValid(input string name);
        int n;
        n = 0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        while (!id_valid && n < 40) begin
            tick();
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            n++;
        end
        if (!id_valid) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: id_valid never rose, got 0 expected 1", name);
        end
    endtask

    task automatic doRedirect(input logic [31:0] target);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, target);
        tick();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
        checkOutput({tag, "_req_addr"},  imem_req_addr, 32'h0);
        checkOutput({tag, "_id_valid"},  32'(id_valid), 32'h0);
        checkOutput({tag, "_id_instr"},  id_instr, NOP);
        checkOutput({tag, "_id_pc"},     id_pc, 32'h0);
        checkOutput({tag, "_id_fault"},  32'(id_fault), 32'h0);
    endtask

    initial begin
        // ctl = {mem ready, id ready, rsp enable, redirect}
        vecs[0]  = '{4'b1110, 32'h0,   1'b0, 32'h000, 1'b0, 32'h000};
        vecs[1]  = '{4'b1110, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000};
        vecs[2]  = '{4'b1110, 32'h0,   1'b1, 32'h004, 1'b0, 32'h000};
        vecs[3]  = '{4'b1110, 32'h0,   1'b0, 32'h008, 1'b1, 32'h000};
        vecs[4]  = '{4'b0110, 32'h0,   1'b1, 32'h008, 1'b1, 32'h004};
        vecs[5]  = '{4'b0110, 32'h0,   1'b1, 32'h008, 1'b0, 32'h000};
        vecs[6]  = '{4'b0110, 32'h0,   1'b1, 32'h008, 1'b0, 32'h000};
        vecs[7]  = '{4'b1110, 32'h0,   1'b1, 32'h008, 1'b0, 32'h000};
        vecs[8]  = '{4'b1110, 32'h0,   1'b1, 32'h00C, 1'b0, 32'h000};
        vecs[9]  = '{4'b1110, 32'h0,   1'b0, 32'h010, 1'b1, 32'h008};
        vecs[10] = '{4'b1010, 32'h0,   1'b1, 32'h010, 1'b1, 32'h00C};
        vecs[11] = '{4'b1010, 32'h0,   1'b0, 32'h014, 1'b1, 32'h00C};
        vecs[12] = '{4'b1010, 32'h0,   1'b0, 32'h014, 1'b1, 32'h00C};
        vecs[13] = '{4'b1110, 32'h0,   1'b0, 32'h014, 1'b1, 32'h00C};
        vecs[14] = '{4'b1010, 32'h0,   1'b1, 32'h014, 1'b1, 32'h010};
        vecs[15] = '{4'b1110, 32'h0,   1'b0, 32'h018, 1'b1, 32'h010};
        vecs[16] = '{4'b1110, 32'h0,   1'b1, 32'h018, 1'b1, 32'h014};
        vecs[17] = '{4'b1100, 32'h0,   1'b1, 32'h01C, 1'b0, 32'h000};
        vecs[18] = '{4'b1101, 32'h100, 1'b0, 32'h020, 1'b0, 32'h000};
        vecs[19] = '{4'b1110, 32'h0,   1'b0, 32'h100, 1'b0, 32'h000};
        vecs[20] = '{4'b1110, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000};
        vecs[21] = '{4'b1110, 32'h0,   1'b1, 32'h104, 1'b0, 32'h000};
        vecs[22] = '{4'b1110, 32'h0,   1'b0, 32'h108, 1'b1, 32'h100};
        vecs[23] = '{4'b0110, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104};
        vecs[24] = '{4'b0111, 32'h200, 1'b1, 32'h108, 1'b0, 32'h000};
        vecs[25] = '{4'b1110, 32'h0,   1'b1, 32'h108, 1'b0, 32'h000};
        vecs[26] = '{4'b1110, 32'h0,   1'b1, 32'h200, 1'b0, 32'h000};
        vecs[27] = '{4'b1110, 32'h0,   1'b1, 32'h204, 1'b0, 32'h000};
        vecs[28] = '{4'b1110, 32'h0,   1'b0, 32'h208, 1'b1, 32'h200};
        vecs[29] = '{4'b1111, 32'h040, 1'b1, 32'h208, 1'b1, 32'h204};
        vecs[30] = '{4'b1110, 32'h0,   1'b1, 32'h040, 1'b0, 32'h000};
        vecs[31] = '{4'b1110, 32'h0,   1'b1, 32'h044, 1'b0, 32'h000};
        vecs[32] = '{4'b1110, 32'h0,   1'b0, 32'h048, 1'b1, 32'h040};

        #1;
        checkReset("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 33; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            applyStimulus(vecs[i].ctl[3], vecs[i].ctl[2], vecs[i].ctl[1], vecs[i].ctl[0], vecs[i].rpc);
            checkOutput({tag, "_req_valid"}, 32'(imem_req_valid), 32'(vecs[i].rv));
            checkOutput({tag, "_req_addr"},  imem_req_addr, vecs[i].addr);
            checkOutput({tag, "_id_valid"},  32'(id_valid), 32'(vecs[i].idv));
            checkOutput({tag, "_id_instr"},  id_instr, vecs[i].idv ? memData(vecs[i].pc) : NOP);
            checkOutput({tag, "_id_fault"},  32'(id_fault), 32'h0);
            if (vecs[i].idv)
                checkOutput({tag, "_id_pc"}, id_pc, vecs[i].pc);
            tick();
        end

        // Back-to-back redirects: only the second target is delivered.
        doRedirect(32'h300);
        doRedirect(32'h400);
        waitValid("b2b");
        checkOutput("b2b_id_pc", id_pc, 32'h400);
        checkOutput("b2b_id_instr", id_instr, memData(32'h400));
        tick();

        // PC wrap at the top of the address space.
        doRedirect(32'hFFFF_FFFC);
        waitValid("wrap0");
        checkOutput("wrap_id_pc0", id_pc, 32'hFFFF_FFFC);
        tick();
        waitValid("wrap1");
        checkOutput("wrap_id_pc1", id_pc, 32'h0000_0000);
        tick();

        // Misaligned redirect target.
        doRedirect(32'h102);
        waitValid("mis0");
        checkOutput("mis_id_pc", id_pc, MIS ? 32'h102 : 32'h100);
        checkOutput("mis_id_fault", 32'(id_fault), 32'(MIS));
        checkOutput("mis_id_instr", id_instr, memData(32'h100));
        tick();
        waitValid("mis1");
        checkOutput("mis_next_pc", id_pc, 32'h104);
        checkOutput("mis_next_fault", 32'(id_fault), 32'h0);
        tick();

        // Asynchronous reset in the middle of streaming.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        memq.delete();
        imem_rsp_valid = 1'b0;
        #1;
        checkReset("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("midrst_boot_req_valid", 32'(imem_req_valid), 32'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("midrst_first_req_valid", 32'(imem_req_valid), 32'h1);
        checkOutput("midrst_first_req_addr", imem_req_addr, 32'h0);
        waitValid("midrst");
        checkOutput("midrst_id_pc", id_pc, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
